// File: rtl/axi_copy_pkg.sv
// Shared types and constants for the AXI4-lite word copy engine.
// Holds the controller state encoding and the fixed AXI attribute values.
package axi_copy_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    WR_RESP = 3'd4,
    FIN     = 3'd5
  } copy_state_e;

  localparam logic [2:0]  PROT_DATA  = 3'b000;
  localparam logic [3:0]  WSTRB_FULL = 4'hF;
  localparam logic [31:0] ADDR_STEP  = 32'd4;

  function automatic logic is_word_aligned(input logic [1:0] i_lsbs);
    return (i_lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/axi_copy_wr_ch.sv
// Write-channel tracker: raises AW and W valids together, retires each on its
// own handshake, and reports the cycle in which both have been accepted.
module axi_copy_wr_ch (
  input  logic clk,
  input  logic resetn,
  input  logic i_active,
  input  logic i_awready,
  input  logic i_wready,
  output logic o_awvalid,
  output logic o_wvalid,
  output logic o_both_done
);

  logic r_aw_done;
  logic r_w_done;
  logic w_aw_hs;
  logic w_w_hs;

  // Valids come only from state and registered flags, never from ready.
  assign o_awvalid   = i_active & ~r_aw_done;
  assign o_wvalid    = i_active & ~r_w_done;
  assign w_aw_hs     = o_awvalid & i_awready;
  assign w_w_hs      = o_wvalid & i_wready;
  assign o_both_done = i_active & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (!i_active || o_both_done) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
    end
  end

endmodule

// File: rtl/axi_lite_copy_engine.sv
// Single-outstanding AXI4-lite copy engine: reads one 32-bit word, writes it
// to the destination, waits for the write response, and repeats len times.
module axi_lite_copy_engine
  import axi_copy_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_axi_awvalid,
  input  logic             mem_axi_awready,
  output logic [31:0]      mem_axi_awaddr,
  output logic [2:0]       mem_axi_awprot,
  output logic             mem_axi_wvalid,
  input  logic             mem_axi_wready,
  output logic [31:0]      mem_axi_wdata,
  output logic [3:0]       mem_axi_wstrb,
  input  logic             mem_axi_bvalid,
  output logic             mem_axi_bready,
  output logic             mem_axi_arvalid,
  input  logic             mem_axi_arready,
  output logic [31:0]      mem_axi_araddr,
  output logic [2:0]       mem_axi_arprot,
  input  logic             mem_axi_rvalid,
  output logic             mem_axi_rready,
  input  logic [31:0]      mem_axi_rdata
);

  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = '0;

  copy_state_e      r_state;
  copy_state_e      w_state_nxt;
  logic             r_armed;
  logic             r_err;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [31:0]      r_buf;
  logic [LEN_W-1:0] r_remain;

  logic w_accept;
  logic w_bad_align;
  logic w_wr_active;
  logic w_wr_done;
  logic w_awvalid;
  logic w_wvalid;
  logic w_r_hs;
  logic w_b_hs;

  // r_armed marks the single cycle after an accepted start: busy is already
  // high, the latched request is checked, and no new start is taken.
  assign w_accept    = (r_state == IDLE) & ~r_armed & start;
  assign w_bad_align = ~is_word_aligned(r_src[1:0]) | ~is_word_aligned(r_dst[1:0]);
  assign w_wr_active = (r_state == WR);
  assign w_r_hs      = (r_state == RD_DATA) & mem_axi_rvalid;
  assign w_b_hs      = (r_state == WR_RESP) & mem_axi_bvalid;

  axi_copy_wr_ch u_wr_ch (
    .clk         (clk),
    .resetn      (resetn),
    .i_active    (w_wr_active),
    .i_awready   (mem_axi_awready),
    .i_wready    (mem_axi_wready),
    .o_awvalid   (w_awvalid),
    .o_wvalid    (w_wvalid),
    .o_both_done (w_wr_done)
  );

  assign mem_axi_awvalid = w_awvalid;
  assign mem_axi_wvalid  = w_wvalid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    busy            = r_armed;
    done            = 1'b0;
    err             = 1'b0;
    mem_axi_arvalid = 1'b0;
    mem_axi_araddr  = '0;
    mem_axi_arprot  = '0;
    mem_axi_rready  = 1'b0;
    mem_axi_awaddr  = '0;
    mem_axi_awprot  = '0;
    mem_axi_wdata   = '0;
    mem_axi_wstrb   = '0;
    mem_axi_bready  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_armed) begin
          if (w_bad_align || (r_remain == LEN_ZERO)) w_state_nxt = FIN;
          else                                       w_state_nxt = RD_ADDR;
        end
      end
      RD_ADDR: begin
        busy            = 1'b1;
        mem_axi_arvalid = 1'b1;
        mem_axi_araddr  = r_src;
        mem_axi_arprot  = PROT_DATA;
        if (mem_axi_arready) w_state_nxt = RD_DATA;
      end
      RD_DATA: begin
        busy           = 1'b1;
        mem_axi_rready = 1'b1;
        if (mem_axi_rvalid) w_state_nxt = WR;
      end
      WR: begin
        busy = 1'b1;
        if (w_awvalid) begin
          mem_axi_awaddr = r_dst;
          mem_axi_awprot = PROT_DATA;
        end
        if (w_wvalid) begin
          mem_axi_wdata = r_buf;
          mem_axi_wstrb = WSTRB_FULL;
        end
        if (w_wr_done) w_state_nxt = WR_RESP;
      end
      WR_RESP: begin
        busy           = 1'b1;
        mem_axi_bready = 1'b1;
        if (mem_axi_bvalid) begin
          if (r_remain == LEN_ONE) w_state_nxt = FIN;
          else                     w_state_nxt = RD_ADDR;
        end
      end
      FIN: begin
        done        = 1'b1;
        err         = r_err;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Addresses advance only after the write response, so a word is never
  // skipped and wrap past 2^32 is plain modular addition.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_armed  <= 1'b0;
      r_err    <= 1'b0;
      r_src    <= '0;
      r_dst    <= '0;
      r_buf    <= '0;
      r_remain <= '0;
    end else begin
      r_armed <= w_accept;
      if (w_accept) begin
        r_src    <= src_addr;
        r_dst    <= dst_addr;
        r_remain <= len_words;
      end
      if ((r_state == IDLE) && r_armed) r_err <= w_bad_align;
      if (w_r_hs) r_buf <= mem_axi_rdata;
      if (w_b_hs) begin
        r_src    <= r_src + ADDR_STEP;
        r_dst    <= r_dst + ADDR_STEP;
        r_remain <= r_remain - LEN_ONE;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_copy_engine.sv
// Scoreboard bench for axi_lite_copy_engine: a memory responder, a word-level
// copy model feeding expectation queues, and a monitor that checks handshakes.
module tb_axi_lite_copy_engine;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [LEN_W-1:0] len_words = '0;
  logic             busy, done, err;
  logic             mem_axi_awvalid, mem_axi_awready;
  logic [31:0]      mem_axi_awaddr;
  logic [2:0]       mem_axi_awprot;
  logic             mem_axi_wvalid, mem_axi_wready;
  logic [31:0]      mem_axi_wdata;
  logic [3:0]       mem_axi_wstrb;
  logic             mem_axi_bvalid, mem_axi_bready;
  logic             mem_axi_arvalid, mem_axi_arready;
  logic [31:0]      mem_axi_araddr;
  logic [2:0]       mem_axi_arprot;
  logic             mem_axi_rvalid, mem_axi_rready;
  logic [31:0]      mem_axi_rdata;

  axi_lite_copy_engine #(.LEN_W(LEN_W)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
    .busy(busy), .done(done), .err(err),
    .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
    .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
    .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
    .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
    .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
    .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
    .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
    .mem_axi_rdata(mem_axi_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word-addressed memory seen by the DUT, and the model's view of it.
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  function automatic int unsigned widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  logic [31:0] q_ar[$];
  logic [31:0] q_aw[$];
  logic [31:0] q_wd[$];
  logic        q_done[$];

  int n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0, n_done = 0, n_vld = 0;

  // ---------------- memory responder ----------------
  bit zw = 1'b1;
  logic        hs_ar, hs_r, hs_aw, hs_w, hs_b;
  logic [31:0] s_araddr, s_awaddr, s_wdata;
  logic        rd_pend, aw_got, w_got, b_pend;
  logic [31:0] rd_addr, aw_addr, w_dat;
  int          rd_wait, b_wait;

  initial begin
    mem_axi_arready = 1'b0; mem_axi_rvalid = 1'b0; mem_axi_rdata = '0;
    mem_axi_awready = 1'b0; mem_axi_wready = 1'b0; mem_axi_bvalid = 1'b0;
    hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0;
    rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
    rd_addr = '0; aw_addr = '0; w_dat = '0; s_araddr = '0; s_awaddr = '0; s_wdata = '0;
    rd_wait = 0; b_wait = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0;
        rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
        mem_axi_arready = 1'b0; mem_axi_rvalid = 1'b0;
        mem_axi_awready = 1'b0; mem_axi_wready = 1'b0; mem_axi_bvalid = 1'b0;
      end else begin
        if (hs_ar) begin rd_pend = 1; rd_addr = s_araddr; rd_wait = zw ? 0 : int'($urandom_range(0, 3)); end
        if (hs_r)  mem_axi_rvalid = 1'b0;
        if (hs_aw) begin aw_got = 1; aw_addr = s_awaddr; end
        if (hs_w)  begin w_got = 1; w_dat = s_wdata; end
        if (hs_b)  mem_axi_bvalid = 1'b0;
        if (aw_got && w_got) begin
          mem[widx(aw_addr)] = w_dat;
          aw_got = 0; w_got = 0;
          b_pend = 1; b_wait = zw ? 0 : int'($urandom_range(0, 3));
        end
        if (rd_pend) begin
          if (rd_wait == 0) begin
            mem_axi_rvalid = 1'b1; mem_axi_rdata = mem[widx(rd_addr)]; rd_pend = 0;
          end else rd_wait--;
        end
        if (b_pend) begin
          if (b_wait == 0) begin mem_axi_bvalid = 1'b1; b_pend = 0; end
          else b_wait--;
        end
        mem_axi_arready = zw ? 1'b1 : ($urandom_range(0, 2) != 0);
        mem_axi_awready = !aw_got && (zw || ($urandom_range(0, 1) == 1));
        mem_axi_wready  = !w_got  && (zw || ($urandom_range(0, 1) == 1));
        // DUT outputs do not depend on our readies, so these are the
        // handshakes that complete at the coming edge.
        hs_ar = mem_axi_arvalid && mem_axi_arready; s_araddr = mem_axi_araddr;
        hs_r  = mem_axi_rvalid && mem_axi_rready;
        hs_aw = mem_axi_awvalid && mem_axi_awready; s_awaddr = mem_axi_awaddr;
        hs_w  = mem_axi_wvalid && mem_axi_wready; s_wdata = mem_axi_wdata;
        hs_b  = mem_axi_bvalid && mem_axi_bready;
      end
    end
  end

  // ---------------- monitor ----------------
  logic        p_ar = 0, p_aw = 0, p_w = 0;
  logic [31:0] p_araddr = '0, p_awaddr = '0, p_wdata = '0;
  logic [3:0]  p_wstrb = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        p_ar = 0; p_aw = 0; p_w = 0;
      end else begin
        if (p_ar) check("ar_stable", 64'({mem_axi_arvalid, mem_axi_araddr}), 64'({1'b1, p_araddr}));
        if (p_aw) check("aw_stable", 64'({mem_axi_awvalid, mem_axi_awaddr}), 64'({1'b1, p_awaddr}));
        if (p_w)  check("w_stable", 64'({mem_axi_wvalid, mem_axi_wstrb, mem_axi_wdata}), 64'({1'b1, p_wstrb, p_wdata}));
        if (mem_axi_arvalid || mem_axi_awvalid || mem_axi_wvalid || mem_axi_rready || mem_axi_bready) begin
          n_vld++;
          check("one_outstanding", 64'($countones({mem_axi_arvalid, mem_axi_rready,
                mem_axi_awvalid | mem_axi_wvalid, mem_axi_bready})), 64'(1));
        end
        if (mem_axi_arvalid && mem_axi_arready) begin
          n_ar++;
          if (q_ar.size() == 0) check("ar_unexpected", 64'(mem_axi_araddr), 64'hDEAD_0000);
          else check("araddr", 64'(mem_axi_araddr), 64'(q_ar.pop_front()));
          check("arprot", 64'(mem_axi_arprot), 64'(0));
        end
        if (mem_axi_rvalid && mem_axi_rready) n_r++;
        if (mem_axi_awvalid && mem_axi_awready) begin
          n_aw++;
          if (q_aw.size() == 0) check("aw_unexpected", 64'(mem_axi_awaddr), 64'hDEAD_0000);
          else check("awaddr", 64'(mem_axi_awaddr), 64'(q_aw.pop_front()));
          check("awprot", 64'(mem_axi_awprot), 64'(0));
        end
        if (mem_axi_wvalid && mem_axi_wready) begin
          n_w++;
          if (q_wd.size() == 0) check("w_unexpected", 64'(mem_axi_wdata), 64'hDEAD_0000);
          else check("wdata", 64'(mem_axi_wdata), 64'(q_wd.pop_front()));
          check("wstrb", 64'(mem_axi_wstrb), 64'hF);
        end
        if (mem_axi_bvalid && mem_axi_bready) n_b++;
        if (done) begin
          n_done++;
          if (q_done.size() == 0) check("done_unexpected", 64'(done), 64'(0));
          else check("done_err", 64'(err), 64'(q_done.pop_front()));
          check("busy_low_at_done", 64'(busy), 64'(0));
        end
        p_ar = mem_axi_arvalid && !mem_axi_arready; p_araddr = mem_axi_araddr;
        p_aw = mem_axi_awvalid && !mem_axi_awready; p_awaddr = mem_axi_awaddr;
        p_w  = mem_axi_wvalid && !mem_axi_wready;   p_wdata = mem_axi_wdata; p_wstrb = mem_axi_wstrb;
      end
    end
  end

  // ---------------- reference model and stimulus ----------------
  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int len, input int n_commit);
    logic [31:0] sa, da, v;
    if (s[1:0] != 2'b00 || d[1:0] != 2'b00) q_done.push_back(1'b1);
    else begin
      for (int i = 0; i < len; i++) begin
        sa = s + 32'(4 * i);
        da = d + 32'(4 * i);
        v  = ref_mem[widx(sa)];
        q_ar.push_back(sa); q_aw.push_back(da); q_wd.push_back(v);
        if (i < n_commit) ref_mem[widx(da)] = v;
      end
      q_done.push_back(1'b0);
    end
  endtask

  task automatic drive_start(input logic [31:0] s, input logic [31:0] d, input int len);
    @(negedge clk);
    src_addr = s; dst_addr = d; len_words = LEN_W'(len); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
  endtask

  task automatic wait_done(input int budget, output int lat);
    int t0;
    t0  = cyc;
    lat = -1;
    for (int k = 0; k < budget; k++) begin
      if (done) begin lat = cyc - t0; break; end
      @(negedge clk);
    end
    if (lat < 0) check("done_timeout", 64'(0), 64'(1));
    repeat (2) @(negedge clk);
  endtask

  task automatic mem_compare(input string name);
    int bad, first;
    bad = 0; first = -1;
    for (int i = 0; i < 1024; i++)
      if (mem[i] !== ref_mem[i]) begin bad++; if (first < 0) first = i; end
    if (bad != 0) $display("  %s: first differing word %0d: 0x%08h vs model 0x%08h",
                           name, first, mem[first], ref_mem[first]);
    check(name, 64'(bad), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, a0, w0, b0, r0, d0, v0, seen;
    logic [31:0] s, d, v, rs, rd;
    logic prev_aw;
    bit hit;

    for (int i = 0; i < 1024; i++) begin v = $urandom; mem[i] = v; ref_mem[i] = v; end
    for (int i = 0; i < 4; i++) begin
      v = 32'h1111_1111 * 32'(i + 1);
      mem[64 + i] = v; ref_mem[64 + i] = v;
    end

    #12;
    check("reset_outputs", 64'({busy, done, err, mem_axi_arvalid, mem_axi_awvalid,
          mem_axi_wvalid, mem_axi_rready, mem_axi_bready}), 64'(0));
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Basic copy, zero-wait responder.
    zw = 1'b1;
    a0 = n_ar; w0 = n_w; b0 = n_b; r0 = n_aw; d0 = n_done;
    model_copy(32'h100, 32'h200, 4, 4);
    drive_start(32'h100, 32'h200, 4);
    wait_done(200, lat);
    check("len4_latency", 64'(lat), 64'(17));
    check("len4_ar_count", 64'(n_ar - a0), 64'(4));
    check("len4_aw_count", 64'(n_aw - r0), 64'(4));
    check("len4_w_count", 64'(n_w - w0), 64'(4));
    check("len4_b_count", 64'(n_b - b0), 64'(4));
    check("len4_done_count", 64'(n_done - d0), 64'(1));
    for (int i = 0; i < 4; i++) check("len4_dst_word", 64'(mem[128 + i]), 64'(32'h1111_1111 * 32'(i + 1)));
    mem_compare("len4_memory");

    // Zero length: completes immediately, no bus activity.
    v0 = n_vld;
    model_copy(32'h100, 32'h300, 0, 0);
    drive_start(32'h100, 32'h300, 0);
    wait_done(20, lat);
    check("len0_latency", 64'(lat), 64'(1));
    check("len0_no_valid", 64'(n_vld - v0), 64'(0));

    // Misaligned source and misaligned destination both report err.
    v0 = n_vld;
    model_copy(32'h102, 32'h300, 2, 2);
    drive_start(32'h102, 32'h300, 2);
    wait_done(20, lat);
    model_copy(32'h100, 32'h301, 1, 1);
    drive_start(32'h100, 32'h301, 1);
    wait_done(20, lat);
    check("misalign_no_valid", 64'(n_vld - v0), 64'(0));
    mem_compare("misalign_memory");

    // Address wrap past 2^32.
    model_copy(32'hFFFF_FFF8, 32'h700, 3, 3);
    drive_start(32'hFFFF_FFF8, 32'h700, 3);
    wait_done(100, lat);
    check("wrap_latency", 64'(lat), 64'(13));
    mem_compare("wrap_memory");

    // Random responder timing, long copy then a few arbitrary ones.
    zw = 1'b0;
    w0 = n_w;
    s = 32'h400 + 32'(4 * $urandom_range(0, 63));
    d = 32'h800 + 32'(4 * $urandom_range(0, 63));
    model_copy(s, d, 64, 64);
    drive_start(s, d, 64);
    wait_done(3000, lat);
    check("len64_w_count", 64'(n_w - w0), 64'(64));
    mem_compare("len64_memory");
    for (int t = 0; t < 3; t++) begin
      s = $urandom & 32'hFFFF_FFFC;
      d = $urandom & 32'hFFFF_FFFC;
      lat = int'($urandom_range(1, 24));
      model_copy(s, d, lat, lat);
      drive_start(s, d, lat);
      wait_done(2000, lat);
    end
    mem_compare("random_memory");

    // Reset while the second word's write is being presented.
    zw = 1'b1;
    model_copy(32'hB00, 32'hC00, 8, 1);
    drive_start(32'hB00, 32'hC00, 8);
    seen = 0; prev_aw = 1'b0; hit = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #3;
      if (mem_axi_awvalid && !prev_aw) seen++;
      prev_aw = mem_axi_awvalid;
      if (seen == 2) begin hit = 1; break; end
    end
    if (!hit) check("word2_aw_seen", 64'(0), 64'(1));
    resetn = 1'b0;
    #1;
    check("midreset_ctrl", 64'({busy, done, err, mem_axi_arvalid, mem_axi_awvalid,
          mem_axi_wvalid, mem_axi_rready, mem_axi_bready, mem_axi_wstrb}), 64'(0));
    check("midreset_addr", 64'({mem_axi_araddr, mem_axi_awaddr}), 64'(0));
    check("midreset_wdata", 64'(mem_axi_wdata), 64'(0));
    q_ar.delete(); q_aw.delete(); q_wd.delete(); q_done.delete();
    repeat (3) @(negedge clk);
    check("held_reset_busy", 64'({busy, mem_axi_arvalid, mem_axi_awvalid}), 64'(0));
    resetn = 1'b1;
    model_copy(32'hB00, 32'hD00, 3, 3);
    drive_start(32'hB00, 32'hD00, 3);
    wait_done(100, lat);
    check("after_reset_latency", 64'(lat), 64'(13));
    mem_compare("after_reset_memory");

    // start held high for the whole copy; later input changes must be ignored.
    d0 = n_done; r0 = n_aw; b0 = n_b;
    model_copy(32'hE00, 32'hF00, 3, 3);
    @(negedge clk);
    src_addr = 32'hE00; dst_addr = 32'hF00; len_words = LEN_W'(3); start = 1'b1;
    hit = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin hit = 1; break; end
      rs = $urandom; rd = $urandom;
      src_addr = rs & 32'hFFFF_FFFC; dst_addr = rd & 32'hFFFF_FFFC;
      len_words = LEN_W'($urandom_range(1, 9));
    end
    start = 1'b0;
    if (!hit) check("pulse_done_seen", 64'(0), 64'(1));
    repeat (20) @(negedge clk);
    check("pulse_done_count", 64'(n_done - d0), 64'(1));
    check("pulse_aw_count", 64'(n_aw - r0), 64'(3));
    check("pulse_b_count", 64'(n_b - b0), 64'(3));
    mem_compare("pulse_memory");

    check("scoreboard_drained", 64'(q_ar.size() + q_aw.size() + q_wd.size() + q_done.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
